// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive path.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } rd_state_e;

  // Released-bus levels; the filters power up here so reset never looks like an edge.
  localparam logic SCL_IDLE = 1'b1;
  localparam logic SDA_IDLE = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Glitch filter: output follows the input after FILTER_LEN consecutive equal samples.
module i2c_glitch_filter #(
  parameter int   FILTER_LEN = 3,
  parameter logic RESET_VAL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int            CW     = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] RELOAD = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt;

  // Down-counter restarts whenever raw matches filt, so any disagreeing run shorter than FILTER_LEN is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= RESET_VAL;
      cnt  <= RELOAD;
    end else if (raw == filt) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      filt <= raw;
      cnt  <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_word_reader.sv
// I2C word receiver: filtered SCL/SDA, START/STOP detection, 1..DATA_WIDTH bit capture.
//   state  | meaning
//   IDLE   | disabled, counter cleared, waiting for rd_en
//   ACTIVE | shifting bits on qualified SCL falls
//   DONE   | word delivered, rd_finish held until rd_en falls
//   ERR    | START/STOP mid-word, bus_err held until rd_en falls
module i2c_word_reader
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      rd_len,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_finish,
  output logic                  get_start,
  output logic                  get_stop,
  output logic                  bus_err
);

  localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_WIDTH);

  rd_state_e             state, state_nxt;
  logic                  scl_f, sda_f, scl_d, sda_d;
  logic                  scl_rise, scl_fall, start_cond, stop_cond;
  logic [CNT_W-1:0]      len, len_sel, counter;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [DATA_WIDTH:0]   shift_cat;
  logic                  sample, sample_valid;
  logic                  bit_take, word_done;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(SCL_IDLE)) u_scl_filt (
    .clk(clk), .rst(rst), .raw(scl_i), .filt(scl_f)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(SDA_IDLE)) u_sda_filt (
    .clk(clk), .rst(rst), .raw(sda_i), .filt(sda_f)
  );

  assign scl_rise   = scl_f & ~scl_d;
  assign scl_fall   = ~scl_f & scl_d;
  // SCL must be high on both sides of the SDA change; a simultaneous SCL fall is ordinary data.
  assign start_cond = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_cond  = scl_f & scl_d & ~sda_d & sda_f;
  assign len_sel    = (rd_len == '0 || rd_len > DW_C) ? DW_C : rd_len;
  assign shift_cat  = {shift_reg, sample};

  always_comb begin
    shift_nxt = shift_reg;
    if (MSB_FIRST) begin
      shift_nxt = shift_cat[DATA_WIDTH-1:0];
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (counter == CNT_W'(i)) shift_nxt[i] = sample;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    bit_take  = 1'b0;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        if (rd_en) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!rd_en) begin
          state_nxt = IDLE;
        end else if ((start_cond || stop_cond) && counter != '0) begin
          state_nxt = ERR;
        end else if (scl_fall && sample_valid) begin
          bit_take = 1'b1;
          if (counter + 1'b1 == len) begin
            word_done = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE, ERR: begin
        if (!rd_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      scl_d        <= SCL_IDLE;
      sda_d        <= SDA_IDLE;
      len          <= DW_C;
      counter      <= '0;
      shift_reg    <= '0;
      sample       <= 1'b0;
      sample_valid <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_finish    <= 1'b0;
      bus_err      <= 1'b0;
      get_start    <= 1'b0;
      get_stop     <= 1'b0;
    end else begin
      state     <= state_nxt;
      scl_d     <= scl_f;
      sda_d     <= sda_f;
      rd_valid  <= word_done;
      rd_finish <= (state_nxt == DONE);
      bus_err   <= (state_nxt == ERR);
      get_start <= start_cond && (state != IDLE);
      get_stop  <= stop_cond && (state != IDLE);
      case (state)
        IDLE: begin
          counter      <= '0;
          sample_valid <= 1'b0;
          if (rd_en) begin
            len       <= len_sel;
            shift_reg <= '0;
          end
        end
        ACTIVE: begin
          if (scl_f) sample <= sda_f;
          if (scl_rise) sample_valid <= 1'b1;
          if (bit_take) begin
            shift_reg    <= shift_nxt;
            counter      <= counter + 1'b1;
            sample_valid <= 1'b0;
          end
          if (word_done) rd_data <= shift_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
